// File: rtl/microc_ctrl.sv
// Control unit for the microc datapath: combinational opcode decode gated by an
// IDLE/RUN/HALT sequencer, plus saturating retired-instruction and taken-jump counters.
module microc_ctrl #(
  parameter int CW = 16
) (
  input  logic          test_clk,
  input  logic          test_reset,
  input  logic [5:0]    opcode,
  input  logic          z,
  input  logic          start,
  output logic          s_inc,
  output logic          s_inm,
  output logic          we3,
  output logic          wez,
  output logic [2:0]    op,
  output logic          pc_hold,
  output logic          halted,
  output logic          illegal,
  output logic [CW-1:0] instr_count,
  output logic [CW-1:0] taken_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
    logic       legal;
    logic       is_halt;
    logic       taken;
  } dec_t;

  state_t     state, state_nxt;
  dec_t       dec;
  logic [1:0] rst_sync;
  logic       rst_n;
  logic       retire, take, set_ill;

  // Assert asynchronously, release two edges after test_reset rises.
  always_ff @(posedge test_clk or negedge test_reset) begin
    if (!test_reset) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_comb begin
    dec         = '0;
    dec.s_inc   = 1'b1;
    dec.legal   = 1'b1;
    if (opcode[5:3] == 3'b000) begin
      dec.op  = opcode[2:0];
      dec.we3 = 1'b1;
      dec.wez = 1'b1;
    end else begin
      case (opcode)
        6'b001000: begin dec.s_inm = 1'b1; dec.we3 = 1'b1; end
        6'b010000: begin dec.s_inc = 1'b0; dec.taken = 1'b1; end
        6'b010001: begin dec.s_inc = ~z;   dec.taken = z;    end
        6'b010010: begin dec.s_inc = z;    dec.taken = ~z;   end
        6'b011111: ;
        6'b111111: dec.is_halt = 1'b1;
        default:   dec.legal   = 1'b0;
      endcase
    end
  end

  // Halt/illegal cycles keep the PC and suppress writes; only legal work retires.
  always_comb begin
    state_nxt = state;
    s_inc     = 1'b1;
    s_inm     = 1'b0;
    we3       = 1'b0;
    wez       = 1'b0;
    op        = 3'b000;
    pc_hold   = 1'b1;
    retire    = 1'b0;
    take      = 1'b0;
    set_ill   = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (dec.is_halt || !dec.legal) begin
          state_nxt = HALT;
          set_ill   = ~dec.legal;
        end else begin
          pc_hold = 1'b0;
          s_inc   = dec.s_inc;
          s_inm   = dec.s_inm;
          we3     = dec.we3;
          wez     = dec.wez;
          op      = dec.op;
          retire  = 1'b1;
          take    = dec.taken;
        end
      end
      HALT: ;
      default: state_nxt = IDLE;
    endcase
  end

  assign halted = (state == HALT);

  always_ff @(posedge test_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      illegal     <= 1'b0;
      instr_count <= '0;
      taken_count <= '0;
    end else begin
      state   <= state_nxt;
      illegal <= illegal | set_ill;
      if (retire && (instr_count != '1)) instr_count <= instr_count + CW'(1);
      if (take && (taken_count != '1))   taken_count <= taken_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_microc_ctrl.sv
// Randomized and directed bench for microc_ctrl: a behavioural model predicts each
// cycle's outputs into a queue that a negedge monitor drains against two DUT widths.
module tb_microc_ctrl;

  localparam int K_ALU = 0, K_LI = 1, K_JMP = 2, K_JZ = 3, K_JNZ = 4, K_NOP = 5,
                 K_HALT = 6, K_ILL = 7;

  typedef struct {
    logic       s_inc, s_inm, we3, wez;
    logic [2:0] op;
    logic       pc_hold, halted, illegal;
    int         ic, tc, ic4, tc4;
  } exp_t;

  typedef struct packed {
    logic [5:0] opc;
    logic [2:0] a, b, d;
    logic [7:0] imm;
  } ins_t;

  logic test_clk = 1'b1;
  logic test_reset = 1'b1;
  logic start = 1'b0;
  logic [5:0] drv_opc = 6'd0;
  logic drv_z = 1'b0;
  logic prog_mode = 1'b0;
  logic [5:0] opcode;
  logic z_sig;

  logic s_inc, s_inm, we3, wez, pc_hold, halted, illegal;
  logic [2:0] op;
  logic [15:0] instr_count, taken_count;
  logic s_inc4, s_inm4, we3_4, wez4, pc_hold4, halted4, illegal4;
  logic [2:0] op4;
  logic [3:0] instr_count4, taken_count4;

  // Small microc datapath so whole programs run closed-loop.
  ins_t prog [16];
  logic [7:0] rf [8];
  logic [3:0] pc;
  logic zf;
  ins_t cur;
  logic [7:0] alu_out;

  int checks = 0, errors = 0;
  exp_t q[$];
  exp_t e_mon;

  bit m_run, m_halt, m_ill;
  int m_sync, m_ic, m_tc, m_ic4, m_tc4;

  always #5 test_clk = ~test_clk;

  microc_ctrl #(.CW(16)) dut (
    .test_clk(test_clk), .test_reset(test_reset), .opcode(opcode), .z(z_sig), .start(start),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .op(op), .pc_hold(pc_hold),
    .halted(halted), .illegal(illegal), .instr_count(instr_count), .taken_count(taken_count));

  microc_ctrl #(.CW(4)) dut4 (
    .test_clk(test_clk), .test_reset(test_reset), .opcode(opcode), .z(z_sig), .start(start),
    .s_inc(s_inc4), .s_inm(s_inm4), .we3(we3_4), .wez(wez4), .op(op4), .pc_hold(pc_hold4),
    .halted(halted4), .illegal(illegal4), .instr_count(instr_count4), .taken_count(taken_count4));

  function automatic logic [7:0] alu_f(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      3'd0: return a;
      3'd1: return ~a;
      3'd2: return a + b;
      3'd3: return a - b;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return -a;
      default: return -b;
    endcase
  endfunction

  assign cur     = prog[pc];
  assign opcode  = prog_mode ? cur.opc : drv_opc;
  assign z_sig   = prog_mode ? zf : drv_z;
  assign alu_out = alu_f(op, rf[cur.a], rf[cur.b]);

  always @(posedge test_clk or negedge test_reset) begin
    if (!test_reset) begin
      pc <= 4'd0;
      zf <= 1'b0;
    end else begin
      if (!pc_hold) pc <= s_inc ? pc + 4'd1 : cur.imm[3:0];
      if (wez) zf <= (alu_out == 8'd0);
      if (we3) rf[cur.d] <= s_inm ? cur.imm : alu_out;
    end
  end

  function automatic int kind(input logic [5:0] o);
    if (o < 6'd8) return K_ALU;
    case (o)
      6'd8:  return K_LI;
      6'd16: return K_JMP;
      6'd17: return K_JZ;
      6'd18: return K_JNZ;
      6'd31: return K_NOP;
      6'd63: return K_HALT;
      default: return K_ILL;
    endcase
  endfunction

  function automatic exp_t model_out(input logic [5:0] o, input logic zz);
    exp_t e;
    int k;
    k = kind(o);
    e.s_inc = 1'b1; e.s_inm = 1'b0; e.we3 = 1'b0; e.wez = 1'b0; e.op = 3'd0;
    e.pc_hold = 1'b1; e.halted = m_halt; e.illegal = m_ill;
    e.ic = m_ic; e.tc = m_tc; e.ic4 = m_ic4; e.tc4 = m_tc4;
    if (m_run && k != K_HALT && k != K_ILL) begin
      e.pc_hold = 1'b0;
      case (k)
        K_ALU: begin e.op = 3'(o % 8); e.we3 = 1'b1; e.wez = 1'b1; end
        K_LI:  begin e.s_inm = 1'b1; e.we3 = 1'b1; end
        K_JMP: e.s_inc = 1'b0;
        K_JZ:  e.s_inc = !zz;
        K_JNZ: e.s_inc = zz;
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic model_step(input logic [5:0] o, input logic zz, input logic st);
    int k;
    bit tk;
    k = kind(o);
    if (m_sync >= 2) begin
      if (!m_run && !m_halt) begin
        if (st) m_run = 1;
      end else if (m_run) begin
        if (k == K_HALT || k == K_ILL) begin
          m_run = 0; m_halt = 1;
          if (k == K_ILL) m_ill = 1;
        end else begin
          tk = (k == K_JMP) || (k == K_JZ && zz) || (k == K_JNZ && !zz);
          if (m_ic < 65535) m_ic++;
          if (m_ic4 < 15) m_ic4++;
          if (tk && m_tc < 65535) m_tc++;
          if (tk && m_tc4 < 15) m_tc4++;
        end
      end
    end
    if (m_sync < 2) m_sync++;
  endtask

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_ill = 0; m_sync = 0;
    m_ic = 0; m_tc = 0; m_ic4 = 0; m_tc4 = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Entered at posedge+1; returns at the next posedge+1.
  task automatic tick();
    logic [5:0] o;
    logic zz, st;
    #1;
    o = opcode; zz = z_sig; st = start;
    q.push_back(model_out(o, zz));
    @(posedge test_clk);
    if (test_reset) model_step(o, zz, st);
    #1;
  endtask

  always @(negedge test_clk) begin
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      chk("s_inc", s_inc, e_mon.s_inc);
      chk("s_inm", s_inm, e_mon.s_inm);
      chk("we3", we3, e_mon.we3);
      chk("wez", wez, e_mon.wez);
      chk("op", op, e_mon.op);
      chk("pc_hold", pc_hold, e_mon.pc_hold);
      chk("halted", halted, e_mon.halted);
      chk("illegal", illegal, e_mon.illegal);
      chk("instr_count", instr_count, e_mon.ic);
      chk("taken_count", taken_count, e_mon.tc);
      chk("cw4_ctrl", {s_inc4, s_inm4, we3_4, wez4, op4, pc_hold4, halted4, illegal4},
          {e_mon.s_inc, e_mon.s_inm, e_mon.we3, e_mon.wez, e_mon.op, e_mon.pc_hold,
           e_mon.halted, e_mon.illegal});
      chk("cw4_instr_count", instr_count4, e_mon.ic4);
      chk("cw4_taken_count", taken_count4, e_mon.tc4);
    end
  end

  task automatic do_reset();
    test_reset = 1'b0;
    model_reset();
    tick();
    test_reset = 1'b1;
  endtask

  task automatic restart();
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 8 && !m_run; i++) tick();
    start = 1'b0;
    checks++;
    if (!m_run) begin
      errors++;
      $display("FAIL restart: got no RUN entry expected RUN within 8 cycles");
    end
  endtask

  task automatic load_prog(input bit with_ill);
    for (int i = 0; i < 16; i++) prog[i] = '{6'd63, 3'd0, 3'd0, 3'd0, 8'd0};
    prog[0] = '{6'b010000, 3'd0, 3'd0, 3'd0, 8'd2};
    prog[1] = '{6'b011111, 3'd0, 3'd0, 3'd0, 8'd0};
    prog[2] = '{6'b001000, 3'd0, 3'd0, 3'd2, 8'd0};
    prog[3] = '{6'b001000, 3'd0, 3'd0, 3'd1, 8'd2};
    prog[4] = '{6'b001000, 3'd0, 3'd0, 3'd3, 8'd4};
    prog[5] = '{6'b001000, 3'd0, 3'd0, 3'd4, 8'd1};
    prog[6] = '{6'b000010, 3'd2, 3'd3, 3'd2, 8'd0};
    prog[7] = with_ill ? '{6'b101010, 3'd1, 3'd4, 3'd1, 8'd0}
                       : '{6'b000011, 3'd1, 3'd4, 3'd1, 8'd0};
    prog[8] = '{6'b010010, 3'd0, 3'd0, 3'd0, 8'd6};
    prog[9] = '{6'b111111, 3'd0, 3'd0, 3'd0, 8'd0};
  endtask

  task automatic run_prog(input int epc, input int er2, input int eic, input int etc, input bit eill);
    for (int i = 0; i < 60 && !m_halt; i++) tick();
    checks++;
    if (!m_halt) begin
      errors++;
      $display("FAIL prog_timeout: got no halt expected halt within 60 cycles");
    end
    chk("prog_r2", rf[2], er2);
    chk("prog_pc", pc, epc);
    chk("prog_instr_count", instr_count, eic);
    chk("prog_taken_count", taken_count, etc);
    chk("prog_halted", halted, 1);
    chk("prog_illegal", illegal, eill);
    tick();
    chk("prog_pc_frozen", pc, epc);
  endtask

  function automatic logic [5:0] rand_opc();
    int r;
    r = $urandom_range(0, 15);
    case (r)
      8:  return 6'd8;
      9:  return 6'd16;
      10: return 6'd17;
      11: return 6'd18;
      12, 15: return 6'd31;
      13: return 6'd63;
      14: return 6'($urandom_range(0, 63));
      default: return 6'(r);
    endcase
  endfunction

  initial begin
    model_reset();
    #1;
    // Idle after reset with start low.
    do_reset();
    for (int i = 0; i < 5; i++) tick();

    // Decode sweep over every opcode with both flag values.
    for (int zv = 0; zv < 2; zv++) begin
      for (int o = 0; o < 64; o++) begin
        if (!m_run) restart();
        drv_opc = 6'(o);
        drv_z = 1'(zv);
        tick();
      end
    end

    // Full program, then the illegal-opcode variant.
    load_prog(0);
    prog_mode = 1'b1;
    restart();
    run_prog(9, 8, 11, 2, 0);
    load_prog(1);
    restart();
    run_prog(7, 4, 6, 1, 1);

    // HALT ignores start; reset clears illegal.
    start = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    start = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) tick();

    // Reset in the middle of the loop, then rerun to the same counts.
    load_prog(0);
    restart();
    for (int i = 0; i < 9; i++) tick();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    restart();
    run_prog(9, 8, 11, 2, 0);

    // Saturation of the 4-bit counters.
    prog_mode = 1'b0;
    restart();
    drv_opc = 6'd31;
    for (int i = 0; i < 20; i++) tick();
    drv_opc = 6'd16;
    for (int i = 0; i < 20; i++) tick();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0 || (m_halt && $urandom_range(0, 3) == 0)) do_reset();
      start = 1'($urandom_range(0, 1));
      drv_z = 1'($urandom_range(0, 1));
      drv_opc = rand_opc();
      tick();
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
